// File: rtl/arb_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, transaction owner
// and the performance counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/arb_perf_cnt.sv
// Saturating event counter used for arbiter statistics; holds at all ones
// instead of wrapping.
module arb_perf_cnt
    import arb_pkg::*;
#(
    parameter int W = PERF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and load/store,
// data side has fixed priority. Optional statistics ports under ARB_PERF_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [XLEN/8-1:0] m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic              m_rvalid,
    input  logic [XLEN-1:0]   m_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_wait_cycles
`endif
);

    arb_state_t state, state_nxt;
    arb_owner_t owner;
    logic       kill;
    logic       resp_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner   <= OWN_IF;
            kill    <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE) begin
                if (d_req) begin
                    owner   <= OWN_D;
                    m_we    <= d_we;
                    m_be    <= d_be;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else if (if_req) begin
                    owner  <= OWN_IF;
                    m_we   <= 1'b0;
                    m_be   <= '1;
                    m_addr <= if_addr;
                end
            end
            // A flushed fetch still finishes on the bus; only its done pulse is lost.
            if (state_nxt == ARB_IDLE) begin
                kill <= 1'b0;
            end else if ((state != ARB_IDLE) && (owner == OWN_IF) && if_kill) begin
                kill <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (d_req || if_req) state_nxt = ARB_ADDR;
            ARB_ADDR: if (m_ready)         state_nxt = ARB_RESP;
            ARB_RESP: if (m_rvalid)        state_nxt = ARB_IDLE;
            default:                       state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_valid   = (state == ARB_ADDR);
        resp_fire = (state == ARB_RESP) && m_rvalid;
        if_done   = resp_fire && (owner == OWN_IF) && !kill && !if_kill;
        d_done    = resp_fire && (owner == OWN_D);
        if_rdata  = m_rdata;
        d_rdata   = m_rdata;
    end

`ifdef ARB_PERF_EN
    logic if_grant, d_grant, wait_cyc;

    always_comb begin
        d_grant  = (state == ARB_IDLE) && d_req;
        if_grant = (state == ARB_IDLE) && !d_req && if_req;
        wait_cyc = (state != ARB_IDLE) &&
                   ((if_req && (owner == OWN_D)) || (d_req && (owner == OWN_IF)));
    end

    arb_perf_cnt #(.W(32)) u_cnt_if   (.clk(clk), .rst(rst), .inc(if_grant), .count(perf_if_grants));
    arb_perf_cnt #(.W(32)) u_cnt_d    (.clk(clk), .rst(rst), .inc(d_grant),  .count(perf_d_grants));
    arb_perf_cnt #(.W(32)) u_cnt_wait (.clk(clk), .rst(rst), .inc(wait_cyc), .count(perf_wait_cycles));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter: one vector per clock cycle plus
// hand-built sequences for backpressure and reset mid-transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, d_req, d_we, m_ready, m_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_done, d_done, m_valid, m_we;
    logic [3:0]  m_be;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int row    = 0;
    int hs_cnt = 0;

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ia;
        logic        kl;
        logic        dr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] da;
        logic [31:0] wd;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_valid;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ifd;
        logic        e_dd;
        logic [31:0] e_rd;
        logic        fchk;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    mem_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) hs_cnt <= hs_cnt + 1;
    end

    function automatic vec_t mk(logic ifr, logic [31:0] ia, logic kl,
                                logic dr, logic we, logic [3:0] be, logic [31:0] da, logic [31:0] wd,
                                logic rdy, logic rv, logic [31:0] rd,
                                logic ev, logic ewe, logic [3:0] ebe, logic [31:0] ea, logic [31:0] ewd,
                                logic eifd, logic edd, logic [31:0] erd);
        vec_t r;
        r.rst = 1'b0; r.ifr = ifr; r.ia = ia; r.kl = kl;
        r.dr = dr; r.we = we; r.be = be; r.da = da; r.wd = wd;
        r.rdy = rdy; r.rv = rv; r.rd = rd;
        r.e_valid = ev; r.e_we = ewe; r.e_be = ebe; r.e_addr = ea; r.e_wd = ewd;
        r.e_ifd = eifd; r.e_dd = edd; r.e_rd = erd; r.fchk = 1'b0;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t s);
        @(posedge clk);
        #1;
        rst      = s.rst;
        if_req   = s.ifr;  if_addr = s.ia;  if_kill = s.kl;
        d_req    = s.dr;   d_we    = s.we;  d_be    = s.be;
        d_addr   = s.da;   d_wdata = s.wd;
        m_ready  = s.rdy;  m_rvalid = s.rv; m_rdata = s.rd;
    endtask

    task automatic checkOutput(vec_t s);
        @(negedge clk);
        check("m_valid", {31'd0, m_valid}, {31'd0, s.e_valid});
        check("if_done", {31'd0, if_done}, {31'd0, s.e_ifd});
        check("d_done",  {31'd0, d_done},  {31'd0, s.e_dd});
        if (s.e_valid || s.fchk) begin
            check("m_we",   {31'd0, m_we}, {31'd0, s.e_we});
            check("m_be",   {28'd0, m_be}, {28'd0, s.e_be});
            check("m_addr", m_addr, s.e_addr);
            if (s.e_we || s.fchk) check("m_wdata", m_wdata, s.e_wd);
        end
        if (s.e_ifd) check("if_rdata", if_rdata, s.e_rd);
        if (s.e_dd)  check("d_rdata",  d_rdata,  s.e_rd);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Simultaneous requests: load wins, fetch follows after the done cycle
        tbl.push_back(mk(1,'h104,0, 1,0,'hF,'h2000,0, 1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h104,0, 1,0,'hF,'h2000,0, 1,0,0,          1,0,'hF,'h2000,0,    0,0,0));
        tbl.push_back(mk(1,'h104,0, 1,0,'hF,'h2000,0, 1,1,'hCAFE0001, 0,0,0,0,0,           0,1,'hCAFE0001));
        tbl.push_back(mk(1,'h104,0, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h104,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h104,0,     0,0,0));
        tbl.push_back(mk(1,'h104,0, 0,0,0,0,0,        1,1,'h93,       0,0,0,0,0,           1,0,'h93));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Fetch only, minimum latency
        tbl.push_back(mk(1,'h100,0, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h100,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h100,0,     0,0,0));
        tbl.push_back(mk(1,'h100,0, 0,0,0,0,0,        1,1,'h13,       0,0,0,0,0,           1,0,'h13));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Kill while in RESP, then a load is served normally
        tbl.push_back(mk(1,'h200,0, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h200,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h200,0,     0,0,0));
        tbl.push_back(mk(1,'h200,1, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        1,1,'h11111111, 0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,     1,0,'hF,'h3000,0, 1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,     1,0,'hF,'h3000,0, 1,0,0,          1,0,'hF,'h3000,0,    0,0,0));
        tbl.push_back(mk(0,0,0,     1,0,'hF,'h3000,0, 1,1,'h55AA55AA, 0,0,0,0,0,           0,1,'h55AA55AA));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Kill in the done cycle itself
        tbl.push_back(mk(1,'h300,0, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h300,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h300,0,     0,0,0));
        tbl.push_back(mk(1,'h300,1, 0,0,0,0,0,        1,1,'h77,       0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Kill in IDLE has no effect
        tbl.push_back(mk(1,'h400,1, 0,0,0,0,0,        1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h400,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h400,0,     0,0,0));
        tbl.push_back(mk(1,'h400,0, 0,0,0,0,0,        1,1,'h400AA,    0,0,0,0,0,           1,0,'h400AA));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Kill never affects a data transaction
        tbl.push_back(mk(0,0,1,     1,0,'hF,'h3004,0, 1,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,1,     1,0,'hF,'h3004,0, 1,0,0,          1,0,'hF,'h3004,0,    0,0,0));
        tbl.push_back(mk(0,0,1,     1,0,'hF,'h3004,0, 1,1,'h12345678, 0,0,0,0,0,           0,1,'h12345678));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Partial store
        tbl.push_back(mk(0,0,0,     1,1,'h3,'h4000,'hDEADBEEF, 1,0,0, 0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,     1,1,'h3,'h4000,'hDEADBEEF, 1,0,0, 1,1,'h3,'h4000,'hDEADBEEF, 0,0,0));
        tbl.push_back(mk(0,0,0,     1,1,'h3,'h4000,'hDEADBEEF, 1,1,0, 0,0,0,0,0,           0,1,0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        // Stray rvalid during ADDR is ignored
        tbl.push_back(mk(1,'h500,0, 0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));
        tbl.push_back(mk(1,'h500,0, 0,0,0,0,0,        0,1,'hBAD,      1,0,'hF,'h500,0,     0,0,0));
        tbl.push_back(mk(1,'h500,0, 0,0,0,0,0,        1,0,0,          1,0,'hF,'h500,0,     0,0,0));
        tbl.push_back(mk(1,'h500,0, 0,0,0,0,0,        1,1,'h99,       0,0,0,0,0,           1,0,'h99));
        tbl.push_back(mk(0,0,0,     0,0,0,0,0,        0,0,0,          0,0,0,0,0,           0,0,0));

        // Reset state, with a stray rvalid present
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_kill = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; m_ready = 0; m_rvalid = 1; m_rdata = 32'h5555;
        repeat (2) @(posedge clk);
        row = -1;
        v = mk(0,0,0, 0,0,0,0,0, 0,1,'h5555, 0,0,0,0,0, 0,0,0);
        v.rst = 1'b1; v.fchk = 1'b1;
        checkOutput(v);

        for (int i = 0; i < tbl.size(); i++) begin
            row = i;
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
`ifdef ARB_PERF_EN
            if (i == 6) begin
                check("perf_if_grants",   perf_if_grants,   32'd1);
                check("perf_d_grants",    perf_d_grants,    32'd1);
                check("perf_wait_cycles", perf_wait_cycles, 32'd2);
            end
`endif
        end

        // Backpressure: four stalled ADDR cycles, exactly one handshake
        row = 100;
        hs_cnt = 0;
        v = mk(0,0,0, 1,0,'hF,'h6000,0, 0,0,0, 0,0,0,0,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        for (int k = 0; k < 4; k++) begin
            row = 101 + k;
            v = mk(0,0,0, 1,0,'hF,'h6000,0, 0,0,0, 1,0,'hF,'h6000,0, 0,0,0);
            if (k == 2) v.da = 32'h6FFF;
            applyStimulus(v); checkOutput(v);
        end
        row = 105;
        v = mk(0,0,0, 1,0,'hF,'h6000,0, 1,0,0, 1,0,'hF,'h6000,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 106;
        v = mk(0,0,0, 1,0,'hF,'h6000,0, 1,0,0, 0,0,0,0,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 107;
        v = mk(0,0,0, 1,0,'hF,'h6000,0, 1,1,'hBEEF0000, 0,0,0,0,0, 0,1,'hBEEF0000);
        applyStimulus(v); checkOutput(v);
        check("handshakes", hs_cnt, 1);
        row = 108;
        v = mk(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0);
        applyStimulus(v); checkOutput(v);

        // Reset while in ADDR abandons the fetch; late rvalid is ignored
        row = 200;
        v = mk(1,'h700,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 201;
        v = mk(1,'h700,0, 0,0,0,0,0, 0,0,0, 1,0,'hF,'h700,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 202;
        v = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1,0,'hF,'h700,0, 0,0,0);
        v.rst = 1'b1;
        applyStimulus(v); checkOutput(v);
        for (int k = 0; k < 2; k++) begin
            row = 203 + k;
            v = mk(0,0,0, 0,0,0,0,0, 0,1,'h42, 0,0,0,0,0, 0,0,0);
            v.fchk = 1'b1;
            applyStimulus(v); checkOutput(v);
        end
        // Normal load after reset
        row = 205;
        v = mk(0,0,0, 1,0,'hF,'h8000,0, 1,0,0, 0,0,0,0,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 206;
        v = mk(0,0,0, 1,0,'hF,'h8000,0, 1,0,0, 1,0,'hF,'h8000,0, 0,0,0);
        applyStimulus(v); checkOutput(v);
        row = 207;
        v = mk(0,0,0, 1,0,'hF,'h8000,0, 1,1,'h0BADF00D, 0,0,0,0,0, 0,1,'h0BADF00D);
        applyStimulus(v); checkOutput(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
